// File: rtl/regfile_writeback_ctrl.sv
// Register-file writeback controller: queues ALU and memory results and drives one write per cycle.
// Build option WB_FORWARD_EN enables forwarding lookups; without it, hit/fwd outputs are tied to 0.
module regfile_writeback_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     hold,
  output logic                     rf_regwrite,
  output logic [ADDR_W-1:0]        rf_register_w,
  output logic [DATA_W-1:0]        rf_write_data,
  input  logic [ADDR_W-1:0]        query_rd_1,
  input  logic [ADDR_W-1:0]        query_rd_2,
  output logic                     hit_1,
  output logic                     hit_2,
  output logic [DATA_W-1:0]        fwd_data_1,
  output logic [DATA_W-1:0]        fwd_data_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  alu_slot;
  logic              mem_enq;
  logic              alu_enq;
  logic              pop;

  // Ready depends only on registered occupancy, so both producers can be accepted together safely.
  assign mem_ready = (count <= CNT_W'(DEPTH - 1));
  assign alu_ready = (count <= CNT_W'(DEPTH - 2));

  // Writes to x0 complete the handshake but are never queued.
  assign mem_enq  = mem_valid & mem_ready & (mem_rd != '0);
  assign alu_enq  = alu_valid & alu_ready & (alu_rd != '0);
  assign pop      = (count != '0) & ~hold;
  assign alu_slot = mem_enq ? (wr_ptr + PTR_W'(1)) : wr_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rf_regwrite   <= 1'b0;
      rf_register_w <= '0;
      rf_write_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(mem_enq) + PTR_W'(alu_enq);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(mem_enq) + CNT_W'(alu_enq) - CNT_W'(pop);
      if (pop) begin
        rf_regwrite   <= 1'b1;
        rf_register_w <= rd_mem[rd_ptr];
        rf_write_data <= data_mem[rd_ptr];
      end else begin
        rf_regwrite   <= 1'b0;
      end
    end
  end

  // Entry storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clock) begin
    if (mem_enq) begin
      rd_mem[wr_ptr]   <= mem_rd;
      data_mem[wr_ptr] <= mem_data;
    end
    if (alu_enq) begin
      rd_mem[alu_slot]   <= alu_rd;
      data_mem[alu_slot] <= alu_data;
    end
  end

`ifdef WB_FORWARD_EN
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    logic [ADDR_W-1:0] q;
    logic              hit_l;
    logic [DATA_W-1:0] fwd_l;

    assign q = (g == 0) ? query_rd_1 : query_rd_2;

    // Scan oldest to youngest so the last match seen is the youngest pending write.
    always_comb begin
      logic [PTR_W-1:0] idx;
      idx   = rd_ptr;
      hit_l = 1'b0;
      fwd_l = '0;
      if (q != '0) begin
        if (rf_regwrite && (rf_register_w == q)) begin
          hit_l = 1'b1;
          fwd_l = rf_write_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
          idx = rd_ptr + PTR_W'(i);
          if ((CNT_W'(i) < count) && (rd_mem[idx] == q)) begin
            hit_l = 1'b1;
            fwd_l = data_mem[idx];
          end
        end
      end
    end
  end

  assign hit_1      = g_fwd[0].hit_l;
  assign fwd_data_1 = g_fwd[0].fwd_l;
  assign hit_2      = g_fwd[1].hit_l;
  assign fwd_data_2 = g_fwd[1].fwd_l;
`else
  logic unused_query;
  assign unused_query = ^{query_rd_1, query_rd_2};
  assign hit_1        = 1'b0;
  assign hit_2        = 1'b0;
  assign fwd_data_1   = '0;
  assign fwd_data_2   = '0;
`endif

endmodule
